// File: rtl/forth_pkg.sv
// Shared types for the Forth processor: arbiter grant/state encodings and default widths.
package forth_pkg;

  localparam int unsigned FORTH_W = 16;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CORE = 2'd1,
    GNT_EXT  = 2'd2
  } gnt_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XACK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dm_arbiter.sv
// Single-port data-memory arbiter between the core load/store path and an external requester.
// DM_ARB_RR_EN selects round-robin contention resolution; otherwise core priority with starvation counter.
module dm_arbiter
  import forth_pkg::*;
#(
  parameter int unsigned AW         = FORTH_W,
  parameter int unsigned DW         = FORTH_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          c_read,
  input  logic          c_write,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_stall,
  input  logic          x_req,
  input  logic          x_we,
  input  logic [AW-1:0] x_addr,
  input  logic [DW-1:0] x_wdata,
  output logic          x_ack,
  output logic [DW-1:0] x_rdata,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic          m_read,
  output logic          m_write,
  input  logic [DW-1:0] m_rdata
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  arb_state_e    state_q, state_d;
  gnt_e          gnt;
  logic          c_req, x_elig, contend;
  logic          x_ack_q;
  logic [DW-1:0] x_rdata_q;
`ifdef DM_ARB_RR_EN
  gnt_e          last_gnt_q, last_gnt_d;
`else
  logic [CW-1:0] starve_q, starve_d;
`endif

  assign c_req   = c_read | c_write;
  assign x_elig  = x_req & (state_q == ARB_IDLE);
  assign contend = c_req & x_elig;

  // Grant decision; reset forces NONE so nothing reaches memory.
  always_comb begin : grant_sel
    gnt = GNT_NONE;
    if (Rst) begin
      gnt = GNT_NONE;
    end else if (contend) begin
`ifdef DM_ARB_RR_EN
      gnt = (last_gnt_q == GNT_CORE) ? GNT_EXT : GNT_CORE;
`else
      gnt = (starve_q == CW'(STARVE_MAX)) ? GNT_EXT : GNT_CORE;
`endif
    end else if (c_req) begin
      gnt = GNT_CORE;
    end else if (x_elig) begin
      gnt = GNT_EXT;
    end
  end

  always_comb begin : mem_mux
    m_addr  = '0;
    m_wdata = '0;
    m_read  = 1'b0;
    m_write = 1'b0;
    case (gnt)
      GNT_CORE: begin
        m_addr  = c_addr;
        m_wdata = c_wdata;
        m_read  = ~c_write;
        m_write = c_write;
      end
      GNT_EXT: begin
        m_addr  = x_addr;
        m_wdata = x_wdata;
        m_read  = ~x_we;
        m_write = x_we;
      end
      default: ;
    endcase
  end

  // Next state: XACK lasts exactly one cycle and only follows an EXT grant.
  always_comb begin : next_state
    state_d = (gnt == GNT_EXT) ? ARB_XACK : ARB_IDLE;
`ifdef DM_ARB_RR_EN
    last_gnt_d = (contend && (gnt != GNT_NONE)) ? gnt : last_gnt_q;
`else
    starve_d = starve_q;
    if ((gnt == GNT_EXT) || !x_elig) begin
      starve_d = '0;
    end else if ((gnt == GNT_CORE) && (starve_q != CW'(STARVE_MAX))) begin
      starve_d = starve_q + CW'(1);
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= ARB_IDLE;
      x_ack_q   <= 1'b0;
      x_rdata_q <= '0;
`ifdef DM_ARB_RR_EN
      last_gnt_q <= GNT_CORE;
`else
      starve_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      x_ack_q   <= (gnt == GNT_EXT);
      x_rdata_q <= ((gnt == GNT_EXT) && !x_we) ? m_rdata : '0;
`ifdef DM_ARB_RR_EN
      last_gnt_q <= last_gnt_d;
`else
      starve_q  <= starve_d;
`endif
    end
  end

  assign c_rdata = m_rdata;
  assign c_stall = c_req & ~Rst & (gnt != GNT_CORE);
  assign x_ack   = x_ack_q;
  assign x_rdata = x_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed vector table, then random traffic against a reference model.
module tb_dm_arbiter;

  localparam int unsigned W    = 16;
  localparam int          SMAX = 4;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         c_read, c_write, x_req, x_we;
  logic [W-1:0] c_addr, c_wdata, x_addr, x_wdata;
  logic [W-1:0] c_rdata, x_rdata, m_addr, m_wdata, m_rdata;
  logic         c_stall, x_ack, m_read, m_write;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  dm_arbiter #(.AW(W), .DW(W), .STARVE_MAX(SMAX)) dut (
    .Clk(Clk), .Rst(Rst),
    .c_read(c_read), .c_write(c_write), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_stall(c_stall),
    .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
    .x_ack(x_ack), .x_rdata(x_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_read(m_read), .m_write(m_write),
    .m_rdata(m_rdata)
  );

  // Behavioural data memory: combinational read, write on the rising edge.
  logic [W-1:0] mem [256] = '{default: 16'h0000};
  assign m_rdata = mem[m_addr[7:0]];
  always @(posedge Clk) if (m_write) mem[m_addr[7:0]] <= m_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic rst, cr, cw; logic [15:0] ca, cd;
    logic xr, xw; logic [15:0] xa, xd;
    logic er, ew, es, ck; logic [15:0] ecrd;
    logic ea; logic [15:0] exrd;
  } vec_t;

  function automatic vec_t v(input logic rst, cr, cw, input logic [15:0] ca, cd,
                             input logic xr, xw, input logic [15:0] xa, xd,
                             input logic er, ew, es, ck, input logic [15:0] ecrd,
                             input logic ea, input logic [15:0] exrd);
    vec_t r;
    r.rst = rst; r.cr = cr; r.cw = cw; r.ca = ca; r.cd = cd;
    r.xr = xr; r.xw = xw; r.xa = xa; r.xd = xd;
    r.er = er; r.ew = ew; r.es = es; r.ck = ck; r.ecrd = ecrd;
    r.ea = ea; r.exrd = exrd;
    return r;
  endfunction

  vec_t tbl[$];

  // Reference-model state for the random phase.
  logic [W-1:0] ref_mem [256] = '{default: 16'h0000};
  bit           ack_now, last_ext, g_core, g_ext, elig, creq, ext_active;
  logic [W-1:0] ack_data;
  int           waited, ext_wait;

  initial begin
    Rst = 1'b1; c_read = 0; c_write = 0; c_addr = '0; c_wdata = '0;
    x_req = 0; x_we = 0; x_addr = '0; x_wdata = '0;
    repeat (2) @(posedge Clk);

    //         rst cr cw ca     cd       xr xw xa     xd       er ew es ck ecrd     ea exrd
    tbl.push_back(v(1, 1, 0, 16'h10, 16'h0,    0, 0, 16'h0,  16'h0,    0, 0, 0, 0, 16'h0,    0, 16'h0));
    tbl.push_back(v(0, 0, 1, 16'h10, 16'hBEEF, 0, 0, 16'h0,  16'h0,    0, 1, 0, 0, 16'h0,    0, 16'h0));
    tbl.push_back(v(0, 1, 0, 16'h10, 16'h0,    0, 0, 16'h0,  16'h0,    1, 0, 0, 1, 16'hBEEF, 0, 16'h0));
    tbl.push_back(v(0, 0, 0, 16'h0,  16'h0,    1, 1, 16'h20, 16'h1234, 0, 1, 0, 0, 16'h0,    0, 16'h0));
    tbl.push_back(v(0, 0, 0, 16'h0,  16'h0,    0, 0, 16'h0,  16'h0,    0, 0, 0, 0, 16'h0,    1, 16'h0));
    tbl.push_back(v(0, 0, 0, 16'h0,  16'h0,    1, 0, 16'h20, 16'h0,    1, 0, 0, 0, 16'h0,    0, 16'h0));
    tbl.push_back(v(0, 0, 0, 16'h0,  16'h0,    0, 0, 16'h0,  16'h0,    0, 0, 0, 0, 16'h0,    1, 16'h1234));
`ifdef DM_ARB_RR_EN
    tbl.push_back(v(0, 1, 0, 16'h10, 16'h0,    1, 0, 16'h10, 16'h0,    1, 0, 1, 0, 16'h0,    0, 16'h0));
    tbl.push_back(v(0, 1, 0, 16'h10, 16'h0,    1, 0, 16'h10, 16'h0,    1, 0, 0, 1, 16'hBEEF, 1, 16'hBEEF));
    tbl.push_back(v(0, 1, 0, 16'h10, 16'h0,    1, 0, 16'h10, 16'h0,    1, 0, 0, 1, 16'hBEEF, 0, 16'h0));
    tbl.push_back(v(0, 1, 0, 16'h10, 16'h0,    1, 0, 16'h10, 16'h0,    1, 0, 1, 0, 16'h0,    0, 16'h0));
    tbl.push_back(v(0, 1, 0, 16'h10, 16'h0,    0, 0, 16'h0,  16'h0,    1, 0, 0, 1, 16'hBEEF, 1, 16'hBEEF));
    tbl.push_back(v(0, 0, 0, 16'h0,  16'h0,    0, 0, 16'h0,  16'h0,    0, 0, 0, 0, 16'h0,    0, 16'h0));
`else
    for (int i = 0; i < SMAX; i++)
      tbl.push_back(v(0, 1, 0, 16'h10, 16'h0,  1, 0, 16'h10, 16'h0,    1, 0, 0, 1, 16'hBEEF, 0, 16'h0));
    tbl.push_back(v(0, 1, 0, 16'h10, 16'h0,    1, 0, 16'h10, 16'h0,    1, 0, 1, 0, 16'h0,    0, 16'h0));
    tbl.push_back(v(0, 1, 0, 16'h10, 16'h0,    0, 0, 16'h0,  16'h0,    1, 0, 0, 1, 16'hBEEF, 1, 16'hBEEF));
`endif
    // Request held through its ack cycle gets no second grant there.
    tbl.push_back(v(0, 0, 0, 16'h0,  16'h0,    1, 1, 16'h30, 16'h5555, 0, 1, 0, 0, 16'h0,    0, 16'h0));
    tbl.push_back(v(0, 0, 0, 16'h0,  16'h0,    1, 1, 16'h30, 16'h5555, 0, 0, 0, 0, 16'h0,    1, 16'h0));
    tbl.push_back(v(0, 0, 0, 16'h0,  16'h0,    0, 0, 16'h0,  16'h0,    0, 0, 0, 0, 16'h0,    0, 16'h0));
    // Reset in an EXT write grant cycle, then confirm memory untouched.
    tbl.push_back(v(1, 0, 0, 16'h0,  16'h0,    1, 1, 16'h40, 16'hAAAA, 0, 0, 0, 0, 16'h0,    0, 16'h0));
    tbl.push_back(v(0, 0, 0, 16'h0,  16'h0,    0, 0, 16'h0,  16'h0,    0, 0, 0, 0, 16'h0,    0, 16'h0));
    tbl.push_back(v(0, 1, 0, 16'h40, 16'h0,    0, 0, 16'h0,  16'h0,    1, 0, 0, 1, 16'h0,    0, 16'h0));
    // Reset during the ack cycle.
    tbl.push_back(v(0, 0, 0, 16'h0,  16'h0,    1, 0, 16'h10, 16'h0,    1, 0, 0, 0, 16'h0,    0, 16'h0));
    tbl.push_back(v(1, 0, 0, 16'h0,  16'h0,    0, 0, 16'h0,  16'h0,    0, 0, 0, 0, 16'h0,    1, 16'hBEEF));
    tbl.push_back(v(0, 0, 0, 16'h0,  16'h0,    0, 0, 16'h0,  16'h0,    0, 0, 0, 0, 16'h0,    0, 16'h0));
    tbl.push_back(v(0, 1, 0, 16'h30, 16'h0,    0, 0, 16'h0,  16'h0,    1, 0, 0, 1, 16'h5555, 0, 16'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge Clk); #1;
      Rst = tbl[i].rst; c_read = tbl[i].cr; c_write = tbl[i].cw;
      c_addr = tbl[i].ca; c_wdata = tbl[i].cd;
      x_req = tbl[i].xr; x_we = tbl[i].xw; x_addr = tbl[i].xa; x_wdata = tbl[i].xd;
      @(negedge Clk);
      chk($sformatf("v%0d_m_read", i),  32'(m_read),  32'(tbl[i].er));
      chk($sformatf("v%0d_m_write", i), 32'(m_write), 32'(tbl[i].ew));
      chk($sformatf("v%0d_c_stall", i), 32'(c_stall), 32'(tbl[i].es));
      chk($sformatf("v%0d_x_ack", i),   32'(x_ack),   32'(tbl[i].ea));
      if (tbl[i].ck) chk($sformatf("v%0d_c_rdata", i), 32'(c_rdata), 32'(tbl[i].ecrd));
      if (tbl[i].ea || (i > 0 && tbl[i-1].rst))
        chk($sformatf("v%0d_x_rdata", i), 32'(x_rdata), 32'(tbl[i].exrd));
    end

    // Random traffic against the reference model (addresses kept in 0x80..0x8F).
    ack_now = 0; ack_data = '0; last_ext = 0; waited = 0; ext_active = 0; ext_wait = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge Clk); #1;
      case ($urandom_range(0, 3))
        0:       begin c_read = 0; c_write = 0; end
        2:       begin c_read = 0; c_write = 1; end
        default: begin c_read = 1; c_write = 0; end
      endcase
      c_addr  = 16'h0080 + 16'($urandom_range(0, 15));
      c_wdata = 16'($urandom);
      if (ext_active) begin
        if (x_ack) ext_active = 0;
        else begin
          ext_wait++;
          if (ext_wait > 16) begin
            checks++; errors++;
            $display("FAIL ext_ack_timeout: waited %0d cycles, required at most 16", ext_wait);
            ext_active = 0;
          end
        end
      end
      if (!ext_active) begin
        if ($urandom_range(0, 1) == 1) begin
          x_req = 1; x_we = 1'($urandom_range(0, 1));
          x_addr = 16'h0080 + 16'($urandom_range(0, 15)); x_wdata = 16'($urandom);
          ext_active = 1; ext_wait = 0;
        end else x_req = 0;
      end
      @(negedge Clk);
      chk("rnd_x_ack", 32'(x_ack), 32'(ack_now));
      if (ack_now) chk("rnd_x_rdata", 32'(x_rdata), 32'(ack_data));
      creq = c_read || c_write;
      elig = x_req && !ack_now;
      if (creq && elig) begin
`ifdef DM_ARB_RR_EN
        g_ext = !last_ext;
`else
        g_ext = (waited == SMAX);
`endif
        g_core = !g_ext;
      end else begin
        g_core = creq;
        g_ext  = elig;
      end
      chk("rnd_c_stall", 32'(c_stall), 32'(creq && !g_core));
      chk("rnd_m_write", 32'(m_write), 32'((g_core && c_write) || (g_ext && x_we)));
      chk("rnd_m_read",  32'(m_read),  32'((g_core && !c_write) || (g_ext && !x_we)));
      if (g_core) chk("rnd_m_addr_core", 32'(m_addr), 32'(c_addr));
      if (g_ext)  chk("rnd_m_addr_ext",  32'(m_addr), 32'(x_addr));
      if (g_core && c_write) chk("rnd_m_wdata_core", 32'(m_wdata), 32'(c_wdata));
      if (g_ext && x_we)     chk("rnd_m_wdata_ext",  32'(m_wdata), 32'(x_wdata));
      if (g_core && !c_write) chk("rnd_c_rdata", 32'(c_rdata), 32'(ref_mem[c_addr[7:0]]));
      // Advance model to the post-edge view.
      ack_now  = g_ext;
      ack_data = x_we ? 16'h0 : ref_mem[x_addr[7:0]];
      if (g_core && c_write) ref_mem[c_addr[7:0]] = c_wdata;
      if (g_ext && x_we)     ref_mem[x_addr[7:0]] = x_wdata;
      if (g_ext || !elig) waited = 0;
      else if (waited < SMAX) waited++;
      if (creq && elig) last_ext = g_ext;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
